// File: rtl/moving_avg_filter.sv
// moving_avg_filter: signed moving-average smoother over a 2^LOG2_DEPTH window.
//   Accepts one sample per edge while ce=1, keeps a running window sum and
//   emits the registered average one edge after each accept once the window
//   is full. clr flushes all window and output state synchronously.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   ce              sample qualifier (din accepted when ce=1 and clr=0)
//   clr             synchronous flush, priority over ce
//   din             signed input sample, DATA_W bits
//   dout            signed window average, held between updates
//   dout_valid      one-cycle pulse for each new fully primed dout
//   primed          high once DEPTH samples accepted since reset/clr
// Build option:
//   SMOOTH_ROUND_EN defined   -> round-half-up average
//   SMOOTH_ROUND_EN undefined -> floor (arithmetic shift) average
module moving_avg_filter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned LOG2_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     primed
);

  localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W  = DATA_W + LOG2_DEPTH;
  localparam int unsigned FILL_W = LOG2_DEPTH + 1;

  logic signed [DATA_W-1:0] win_q [DEPTH];
  logic signed [DATA_W-1:0] win_d [DEPTH];
  logic [LOG2_DEPTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic                     primed_q, primed_d;
  logic                     upd_q, upd_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic signed [DATA_W-1:0] avg_c;

  // Average of the current window sum; the sum never exceeds DATA_W bits
  // after the shift, so the slice is the full arithmetic-shift result.
`ifdef SMOOTH_ROUND_EN
  localparam int unsigned HALF = 1 << (LOG2_DEPTH - 1);
  logic signed [SUM_W:0] rnd_c;
  logic                  unused_rnd_c;
  assign rnd_c        = (SUM_W+1)'(sum_q) + (SUM_W+1)'(HALF);
  assign avg_c        = rnd_c[LOG2_DEPTH +: DATA_W];
  assign unused_rnd_c = ^{rnd_c[SUM_W], rnd_c[LOG2_DEPTH-1:0]};
`else
  assign avg_c = sum_q[LOG2_DEPTH +: DATA_W];
`endif

  // Next-state: window update on accept, output update one edge later.
  always_comb begin
    win_d        = win_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    sum_d        = sum_q;
    primed_d     = primed_q;
    upd_d        = 1'b0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (clr) begin
      // Flush everything; the pending output update is dropped with it.
      for (int i = 0; i < int'(DEPTH); i++) win_d[i] = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
      sum_d    = '0;
      primed_d = 1'b0;
      dout_d   = '0;
    end else begin
      if (upd_q) begin
        dout_d       = avg_c;
        dout_valid_d = 1'b1;
      end
      if (ce) begin
        // Oldest entry is the one being overwritten at wr_ptr.
        sum_d           = sum_q + SUM_W'(din) - SUM_W'(win_q[wr_ptr_q]);
        win_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + LOG2_DEPTH'(1);
        if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + FILL_W'(1);
        primed_d        = (fill_d == FILL_W'(DEPTH));
        upd_d           = primed_d;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      sum_q        <= '0;
      primed_q     <= 1'b0;
      upd_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      sum_q        <= sum_d;
      primed_q     <= primed_d;
      upd_q        <= upd_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign primed     = primed_q;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter with DATA_W=8, LOG2_DEPTH=2.
module tb_moving_avg_filter;

  logic              clk;
  logic              rst_n;
  logic              ce;
  logic              clr;
  logic signed [7:0] din;
  logic signed [7:0] dout;
  logic              dout_valid;
  logic              primed;

  int n_cmp;
  int n_err;

  moving_avg_filter #(.DATA_W(8), .LOG2_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .din(din),
    .dout(dout), .dout_valid(dout_valid), .primed(primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic signed [7:0] v);
    ce  = 1'b1;
    clr = 1'b0;
    din = v;
    cyc();
    ce  = 1'b0;
  endtask

  // Flush with a simultaneous sample that must be discarded.
  task automatic do_clr();
    clr = 1'b1;
    ce  = 1'b1;
    din = 8'sd55;
    cyc();
    clr = 1'b0;
    ce  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b0; clr = 1'b0; din = '0;
    cyc(); cyc();
    n_cmp++; if (dout !== 8'sd0) begin n_err++; $display("FAIL reset_dout got %0d exp 0", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b exp 0", dout_valid); end
    n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL reset_primed got %0b exp 0", primed); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_fill_100();
    for (int i = 0; i < 4; i++) begin
      push(8'sd100);
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL fill100_early_valid[%0d] got %0b exp 0", i, dout_valid); end
      n_cmp++; if (primed !== (i == 3)) begin n_err++; $display("FAIL fill100_primed[%0d] got %0b exp %0b", i, primed, (i == 3)); end
    end
    cyc();
    n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL fill100_valid got %0b exp 1", dout_valid); end
    n_cmp++; if (dout !== 8'sd100) begin n_err++; $display("FAIL fill100_dout got %0d exp 100", dout); end
    cyc();
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL fill100_pulse got %0b exp 0", dout_valid); end
    n_cmp++; if (dout !== 8'sd100) begin n_err++; $display("FAIL fill100_hold got %0d exp 100", dout); end
  endtask

  // Ramp 0->8 back-to-back; crosses the pointer wrap with ce held high.
  task automatic test_back_to_back();
    logic signed [7:0] exp_v;
    do_clr();
    for (int i = 0; i < 4; i++) push(8'sd0);
    for (int j = 0; j < 4; j++) begin
      push(8'sd8);
      exp_v = 8'(2 * j);
      n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL ramp_valid[%0d] got %0b exp 1", j, dout_valid); end
      n_cmp++; if (dout !== exp_v) begin n_err++; $display("FAIL ramp_dout[%0d] got %0d exp %0d", j, dout, exp_v); end
    end
    cyc();
    n_cmp++; if (dout !== 8'sd8) begin n_err++; $display("FAIL ramp_final got %0d exp 8", dout); end
  endtask

  task automatic test_negative();
    logic signed [7:0] exp_v;
`ifdef SMOOTH_ROUND_EN
    exp_v = 8'sd0;
`else
    exp_v = -8'sd1;
`endif
    do_clr();
    for (int i = 0; i < 4; i++) push(8'sd0);
    push(-8'sd1);
    cyc();
    n_cmp++; if (dout !== exp_v) begin n_err++; $display("FAIL neg1_dout got %0d exp %0d", dout, exp_v); end
  endtask

  task automatic test_extremes();
    logic signed [7:0] exp_alt;
`ifdef SMOOTH_ROUND_EN
    exp_alt = 8'sd0;
`else
    exp_alt = -8'sd1;
`endif
    do_clr();
    for (int i = 0; i < 4; i++) push(-8'sd128);
    cyc();
    n_cmp++; if (dout !== -8'sd128) begin n_err++; $display("FAIL ext_min got %0d exp -128", dout); end
    for (int i = 0; i < 4; i++) push(8'sd127);
    cyc();
    n_cmp++; if (dout !== 8'sd127) begin n_err++; $display("FAIL ext_max got %0d exp 127", dout); end
    for (int i = 0; i < 4; i++) push((i % 2 == 0) ? -8'sd128 : 8'sd127);
    cyc();
    n_cmp++; if (dout !== exp_alt) begin n_err++; $display("FAIL ext_alt got %0d exp %0d", dout, exp_alt); end
  endtask

  task automatic test_ce_gaps();
    do_clr();
    for (int i = 0; i < 5; i++) begin
      push(8'sd4);
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL gap_valid_at_accept[%0d] got %0b exp 0", i, dout_valid); end
      for (int g = 0; g < 3; g++) begin
        cyc();
        n_cmp++; if (dout_valid !== (i >= 3 && g == 0)) begin n_err++; $display("FAIL gap_valid[%0d.%0d] got %0b exp %0b", i, g, dout_valid, (i >= 3 && g == 0)); end
        n_cmp++; if (dout !== ((i >= 3) ? 8'sd4 : 8'sd0)) begin n_err++; $display("FAIL gap_dout[%0d.%0d] got %0d exp %0d", i, g, dout, ((i >= 3) ? 4 : 0)); end
        n_cmp++; if (primed !== (i >= 3)) begin n_err++; $display("FAIL gap_primed[%0d.%0d] got %0b exp %0b", i, g, primed, (i >= 3)); end
      end
    end
  endtask

  task automatic test_clr_mid();
    do_clr();
    push(8'sd10);
    push(8'sd20);
    do_clr();
    n_cmp++; if (dout !== 8'sd0) begin n_err++; $display("FAIL clr_dout got %0d exp 0", dout); end
    n_cmp++; if (primed !== 1'b0) begin n_err++; $display("FAIL clr_primed got %0b exp 0", primed); end
    for (int i = 0; i < 4; i++) begin
      push(8'sd40);
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL clr_early_valid[%0d] got %0b exp 0", i, dout_valid); end
      n_cmp++; if (primed !== (i == 3)) begin n_err++; $display("FAIL clr_primed[%0d] got %0b exp %0b", i, primed, (i == 3)); end
    end
    cyc();
    n_cmp++; if (dout !== 8'sd40 || dout_valid !== 1'b1) begin n_err++; $display("FAIL clr_recover got %0d/%0b exp 40/1", dout, dout_valid); end
    // clr right after a primed accept cancels the pending pulse.
    push(8'sd40);
    do_clr();
    n_cmp++; if (dout_valid !== 1'b0 || dout !== 8'sd0) begin n_err++; $display("FAIL clr_cancel got %0d/%0b exp 0/0", dout, dout_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) push(8'sd12);
    cyc();
    push(8'sd1);
    push(8'sd2);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dout !== 8'sd0 || dout_valid !== 1'b0 || primed !== 1'b0) begin n_err++; $display("FAIL rstmid_async got %0d/%0b/%0b exp 0/0/0", dout, dout_valid, primed); end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(-8'sd20);
      n_cmp++; if (primed !== (i == 3) || dout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_refill[%0d] got %0b/%0b exp %0b/0", i, primed, dout_valid, (i == 3)); end
    end
    cyc();
    n_cmp++; if (dout !== -8'sd20 || dout_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_recover got %0d/%0b exp -20/1", dout, dout_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill_100();
    test_back_to_back();
    test_negative();
    test_extremes();
    test_ce_gaps();
    test_clr_mid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
